mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the core's data-memory bus, in parallel with dmem and sharing the same MemWriteM / DataAdrM / WriteDataM / funct3-byte-enable signals. Stores to its address window push bytes into a small TX FIFO. A baud-rate generator and a 8N1 serialiser drain the FIFO onto a serial line. Loads return status and configuration through a combinational read path, with the same timing as dmem.

---
 rtl/mmio_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA feed a small FIFO that is
// drained by a baud counter and serialiser; STATUS/DIVISOR are read combinationally.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [2:0]  be,
    output logic [31:0] rd,
    output logic        sel,
    output logic        txd,
    output logic        irq
);
    // state | meaning
    // IDLE  | line high, waiting for a queued byte
    // START | start bit (low) for div cycles
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit (high); pops the next byte directly if one is queued
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [3:0]    count;
    logic          overflow;
    logic [15:0]   div, div_eff, baud_load, baud_cnt;
    logic [1:0]    state;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          txd_q;
    logic          wr_tx, wr_st, wr_div, push, pop, empty, full, busy, bit_end;
    logic          unused_ok;

    assign unused_ok = ^{a[1:0], wd[31:16]};

    assign sel    = (a[31:4] == BASE_ADDR[31:4]) && (a[3:2] != 2'b11);
    assign wr_tx  = we && sel && (a[3:2] == 2'b00);
    assign wr_st  = we && sel && (a[3:2] == 2'b01);
    assign wr_div = we && sel && (a[3:2] == 2'b10);

    assign empty = (count == 4'd0);
    assign full  = (count == DEPTH_C);
    assign busy  = (state != S_IDLE);
    assign irq   = empty && !busy;
    assign txd   = txd_q;

    assign div_eff   = (div == 16'd0) ? 16'd1 : div;
    assign baud_load = div_eff - 16'd1;
    assign bit_end   = (baud_cnt == 16'd0);

    // A byte leaves the FIFO when idle, or at the end of a stop bit for back-to-back frames.
    assign push = wr_tx && !full;
    assign pop  = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wd[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
            div      <= DIV_RESET;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            // A push against a full FIFO is lost even if a pop frees a slot on the same edge.
            if (wr_tx && full)
                overflow <= 1'b1;
            else if (wr_st && wd[3])
                overflow <= 1'b0;
            if (wr_div) begin
                if (be == 3'b000) div[7:0] <= wd[7:0];
                else              div      <= wd[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            txd_q    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= mem[rptr];
                        state    <= S_START;
                        txd_q    <= 1'b0;
                        baud_cnt <= baud_load;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        bit_idx  <= 3'd0;
                        txd_q    <= shift[0];
                        baud_cnt <= baud_load;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= baud_load;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            txd_q <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            txd_q   <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift    <= mem[rptr];
                            state    <= S_START;
                            txd_q    <= 1'b0;
                            baud_cnt <= baud_load;
                        end else begin
                            state <= S_IDLE;
                            txd_q <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rd = 32'd0;
        if (sel) begin
            case (a[3:2])
                2'b01:   rd = {24'd0, count, overflow, empty, full, busy};
                2'b10:   rd = {16'd0, div};
                default: rd = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench for mmio_uart_tx: stores queue expected bytes, a line monitor
// decodes txd frames at the programmed bit time and checks them against the queue.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] wd = 32'd0;
    logic [2:0]  be = 3'b010;
    logic [31:0] rd;
    logic        sel, txd, irq;

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .be(be),
        .rd(rd), .sel(sel), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  stim_q[$];
    logic [15:0] div_m = 16'd434;
    int          mon_div = 434;
    int          k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    // Model of a store: updates the bench's view of the divisor.
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        we = 1'b1; a = addr; wd = data; be = f3;
        @(posedge clk); k++; #1;
        we = 1'b0;
        if (addr == BASE + 32'h8) begin
            if (f3 == 3'b000) div_m[7:0] = data[7:0];
            else              div_m      = data[15:0];
            mon_div = eff_div(div_m);
        end
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        we = 1'b0; a = addr; #1;
        data = rd;
    endtask

    // Pushes stim_q on consecutive edges starting from an idle, empty transmitter.
    // One byte is popped on the edge after the first push, so DEPTH+1 bytes fit.
    task automatic push_seq();
        int n;
        n = stim_q.size();
        k = -1;
        for (int i = 0; i < n; i++) begin
            we = 1'b1; a = BASE; wd = {$urandom} & 32'hFFFF_FF00 | 32'(stim_q[i]);
            be = 3'($urandom_range(0, 7));
            if (i < DEPTH + 1) exp_q.push_back(stim_q[i]);
            @(posedge clk); k++; #1;
        end
        we = 1'b0;
        stim_q.delete();
    endtask

    // Frames must run back-to-back: irq returns exactly 1 + 10*div*frames edges after the first push.
    task automatic drain(input string name, input int frames);
        int lim;
        lim = 10 * mon_div * frames + 50;
        while (irq !== 1'b1 && k < lim) begin
            @(posedge clk); k++; #1;
        end
        chk(name, 32'(k), 32'(1 + 10 * mon_div * frames));
    endtask

    initial begin : monitor
        logic       active;
        logic [9:0] bits;
        logic       frame_err;
        int         pos, cur_div, bidx, off;
        logic [7:0] e;
        active = 1'b0; bits = '0; frame_err = 1'b0; pos = 0; cur_div = 1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                active = 1'b0;
            end else if (!active && txd === 1'b0) begin
                active = 1'b1; pos = 0; cur_div = mon_div; frame_err = 1'b0; bits = '0;
            end
            if (active) begin
                bidx = pos / cur_div;
                off  = pos % cur_div;
                if (off == 0) bits[bidx] = txd;
                else if (txd !== bits[bidx]) frame_err = 1'b1;
                if (pos == 10 * cur_div - 1) begin
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) frame_err = 1'b1;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_byte", 32'(bits[8:1]), 32'(e));
                        chk("frame_shape", 32'(frame_err), 32'd0);
                    end
                    active = 1'b0;
                end else begin
                    pos++;
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] r;
        int          lows, len;
        k = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_irq", 32'(irq), 32'd1);
        bus_rd(BASE + 32'h4, r); chk("reset_status", r, 32'h4);
        bus_rd(BASE + 32'h8, r); chk("reset_divisor", r, 32'h1B2);
        bus_rd(BASE, r);
        chk("sel_txdata", 32'(sel), 32'd1);
        chk("rd_txdata", r, 32'd0);

        bus_wr(BASE + 32'h8, 32'd4, 3'b010);
        stim_q.push_back(8'hA5);
        push_seq();
        drain("a5_irq_cycles", 1);

        bus_wr(BASE + 32'h8, 32'd2, 3'b010);
        for (int i = 0; i < 10; i++) stim_q.push_back(8'(8'h30 + i * 7));
        push_seq();
        bus_rd(BASE + 32'h4, r); chk("status_full_ovf", r, 32'h8B);
        bus_wr(BASE + 32'h4, 32'h8, 3'b010);
        bus_rd(BASE + 32'h4, r); chk("status_ovf_cleared", r, 32'h83);
        drain("burst9_cycles", 9);
        bus_rd(BASE + 32'h4, r); chk("status_drained", r, 32'h4);

        bus_wr(BASE + 32'h8, 32'h0104, 3'b010);
        bus_wr(BASE + 32'h8, 32'hAABB_CC03, 3'b000);
        bus_rd(BASE + 32'h8, r); chk("divisor_sb", r, 32'h103);
        bus_wr(BASE + 32'h8, 32'hFFFF_0000, 3'b010);
        bus_rd(BASE + 32'h8, r); chk("divisor_zero", r, 32'h0);
        stim_q.push_back(8'h00);
        push_seq();
        drain("div0_cycles", 1);

        for (int t = 0; t < 6; t++) begin
            bus_wr(BASE + 32'h8, 32'($urandom_range(1, 6)), 3'($urandom_range(1, 7)));
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom));
            push_seq();
            drain("rand_burst_cycles", len);
        end

        we = 1'b1; a = BASE + 32'hC; wd = 32'h8; be = 3'b010; #1;
        chk("sel_off_c", 32'(sel), 32'd0);
        chk("rd_off_c", rd, 32'd0);
        @(posedge clk); #1;
        a = BASE + 32'h10; wd = 32'h55; #1;
        chk("sel_off_10", 32'(sel), 32'd0);
        chk("rd_off_10", rd, 32'd0);
        @(posedge clk); #1;
        we = 1'b0;
        bus_rd(BASE + 32'h4, r); chk("status_after_unmapped", r, 32'h4);
        bus_rd(BASE + 32'h8, r); chk("divisor_after_unmapped", r, 32'(div_m));

        bus_wr(BASE + 32'h8, 32'd4, 3'b010);
        stim_q.push_back(8'h00); stim_q.push_back(8'h11); stim_q.push_back(8'h22);
        push_seq();
        while (k < 18) begin
            @(posedge clk); k++; #1;
        end
        chk("txd_bit3_before_reset", 32'(txd), 32'd0);
        #2 reset = 1'b0;
        #1 chk("txd_async_reset", 32'(txd), 32'd1);
        exp_q.delete();
        div_m = 16'd434;
        mon_div = 434;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        bus_rd(BASE + 32'h4, r); chk("status_after_reset", r, 32'h4);
        chk("irq_after_reset", 32'(irq), 32'd1);
        bus_rd(BASE + 32'h8, r); chk("divisor_after_reset", r, 32'h1B2);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        chk("no_frame_after_reset", 32'(lows), 32'd0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
